// File: rtl/game_step_ctrl.sv
// game_step_ctrl: step sequencer for the colour-matching game.
// A raw button is synchronised and edge-detected. Each press advances one
// phase: IDLE -> FIRST -> SECOND -> (evaluate) -> REVEAL... -> IDLE or DONE.
// The evaluating press checks the sel_a/sel_b pair against the pairing rule
// and the set of squares that are already matched.
module game_step_ctrl #(
  parameter int NUM_SQ       = 4,
  parameter int IDX_W        = 3,
  parameter int PAIR_MODE    = 0,
  parameter int REVEAL_STEPS = 3,
  parameter int MISS_W       = 8,
  localparam int STEP_W      = $clog2(REVEAL_STEPS + 4),
  localparam int SCORE_W     = $clog2(NUM_SQ / 2 + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [IDX_W-1:0]   sel_a,
  input  logic [IDX_W-1:0]   sel_b,
  output logic [STEP_W-1:0]  step,
  output logic [NUM_SQ-1:0]  matched_mask,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic               match_pulse,
  output logic               miss_pulse,
  output logic               done
);

  typedef enum logic [STEP_W-1:0] {
    ST_IDLE   = STEP_W'(0),
    ST_FIRST  = STEP_W'(1),
    ST_SECOND = STEP_W'(2),
    ST_DONE   = STEP_W'(3 + REVEAL_STEPS)
  } step_e;

  localparam logic [STEP_W-1:0]  ST_REVEAL0  = STEP_W'(3);
  localparam logic [STEP_W-1:0]  LAST_REVEAL = STEP_W'(2 + REVEAL_STEPS);
  localparam logic [SCORE_W-1:0] FULL_SCORE  = SCORE_W'(NUM_SQ / 2);
  localparam logic [IDX_W:0]     NUM_SQ_X    = (IDX_W + 1)'(NUM_SQ);
  localparam logic [IDX_W:0]     MIRROR_SUM  = (IDX_W + 1)'(NUM_SQ - 1);

  logic               sync1_q, sync2_q, prev_q;
  logic               press;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [NUM_SQ-1:0]  mask_q, mask_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic               match_pulse_q, match_pulse_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               done_q, done_d;

  logic [NUM_SQ-1:0]  onehot_a, onehot_b;
  logic               a_in_range, b_in_range, rule_ok, already_hit, pair_ok;

  // Button synchroniser and previous-level flop; all preset to 1 so a button
  // held through reset release is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~prev_q;

  // One-hot decode of each selection; out-of-range indices decode to zero,
  // so they can never touch the matched mask.
  for (genvar gi = 0; gi < NUM_SQ; gi++) begin : g_decode
    assign onehot_a[gi] = (sel_a == IDX_W'(gi));
    assign onehot_b[gi] = (sel_b == IDX_W'(gi));
  end

  assign a_in_range  = ({1'b0, sel_a} < NUM_SQ_X);
  assign b_in_range  = ({1'b0, sel_b} < NUM_SQ_X);
  // Both rules are symmetric in a/b, so either selection order is accepted.
  assign rule_ok     = (PAIR_MODE == 1) ? (sel_a == (sel_b ^ IDX_W'(1)))
                                        : (({1'b0, sel_a} + {1'b0, sel_b}) == MIRROR_SUM);
  assign already_hit = |(mask_q & (onehot_a | onehot_b));
  assign pair_ok     = a_in_range && b_in_range && (sel_a != sel_b)
                       && rule_ok && !already_hit;

  // Next-state and bookkeeping: everything holds unless a press arrives.
  always_comb begin
    step_d        = step_q;
    mask_d        = mask_q;
    score_d       = score_q;
    misses_d      = misses_q;
    match_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    if (press) begin
      case (step_q)
        ST_IDLE:   step_d = ST_FIRST;
        ST_FIRST:  step_d = ST_SECOND;
        ST_SECOND: begin
          if (pair_ok) begin
            mask_d        = mask_q | onehot_a | onehot_b;
            score_d       = score_q + SCORE_W'(1);
            match_pulse_d = 1'b1;
            step_d        = ST_REVEAL0;
          end else begin
            if (misses_q != '1) misses_d = misses_q + MISS_W'(1);
            miss_pulse_d = 1'b1;
            step_d       = ST_IDLE;
          end
        end
        ST_DONE:   step_d = ST_DONE;
        default: begin
          if (step_q == LAST_REVEAL)
            step_d = (score_q == FULL_SCORE) ? ST_DONE : ST_IDLE;
          else
            step_d = step_q + STEP_W'(1);
        end
      endcase
    end
    done_d = (step_d == ST_DONE);
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q        <= '0;
      mask_q        <= '0;
      score_q       <= '0;
      misses_q      <= '0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      step_q        <= step_d;
      mask_q        <= mask_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      match_pulse_q <= match_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      done_q        <= done_d;
    end
  end

  assign step         = step_q;
  assign matched_mask = mask_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign match_pulse  = match_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign done         = done_q;

endmodule

// File: tb/tb_game_step_ctrl.sv
// Directed bench for game_step_ctrl: default mirror configuration (dut1)
// and an adjacent-pairing, 8-square configuration (dut2).
module tb_game_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn1 = 1'b0, btn2 = 1'b0;
  logic [2:0] sa1 = '0, sb1 = '0, sa2 = '0, sb2 = '0;

  logic [2:0] step1, step2;
  logic [3:0] mask1;
  logic [7:0] mask2;
  logic [1:0] score1;
  logic [2:0] score2;
  logic [7:0] miss1, miss2;
  logic       mp1, xp1, done1, mp2, xp2, done2;

  int checks = 0;
  int errors = 0;
  int mcnt1 = 0, xcnt1 = 0, mcnt2 = 0, xcnt2 = 0;
  int m0, x0;

  always #5 clk = ~clk;

  game_step_ctrl dut1 (
    .clk(clk), .rst(rst), .btn(btn1), .sel_a(sa1), .sel_b(sb1),
    .step(step1), .matched_mask(mask1), .score(score1), .misses(miss1),
    .match_pulse(mp1), .miss_pulse(xp1), .done(done1)
  );

  game_step_ctrl #(.NUM_SQ(8), .IDX_W(3), .PAIR_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .btn(btn2), .sel_a(sa2), .sel_b(sb2),
    .step(step2), .matched_mask(mask2), .score(score2), .misses(miss2),
    .match_pulse(mp2), .miss_pulse(xp2), .done(done2)
  );

  // Count strobe cycles away from the active edge.
  always @(negedge clk) begin
    if (mp1 === 1'b1) mcnt1++;
    if (xp1 === 1'b1) xcnt1++;
    if (mp2 === 1'b1) mcnt2++;
    if (xp2 === 1'b1) xcnt2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    if (which == 1) btn1 = 1'b1; else btn2 = 1'b1;
    repeat (3) @(negedge clk);
    if (which == 1) btn1 = 1'b0; else btn2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero1(input string tag);
    check({tag, "_step"}, 32'(step1), 32'd0);
    check({tag, "_mask"}, 32'(mask1), 32'd0);
    check({tag, "_score"}, 32'(score1), 32'd0);
    check({tag, "_misses"}, 32'(miss1), 32'd0);
    check({tag, "_pulses"}, 32'({mp1, xp1}), 32'd0);
    check({tag, "_done"}, 32'(done1), 32'd0);
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero1("reset");
    check("reset_step2", 32'(step2), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mismatch 0/1 under the mirror rule.
    sa1 = 3'd0; sb1 = 3'd1;
    press(1); check("mm_step1", 32'(step1), 32'd1);
    press(1); check("mm_step2", 32'(step1), 32'd2);
    x0 = xcnt1; m0 = mcnt1;
    press(1);
    check("mm_step0", 32'(step1), 32'd0);
    check("mm_misses", 32'(miss1), 32'd1);
    check("mm_miss_pulse_cycles", 32'(xcnt1 - x0), 32'd1);
    check("mm_no_match_pulse", 32'(mcnt1 - m0), 32'd0);
    check("mm_mask", 32'(mask1), 32'd0);
    check("mm_score", 32'(score1), 32'd0);

    // Valid pair 3/0, then through reveal back to idle.
    sa1 = 3'd3; sb1 = 3'd0;
    press(1); press(1);
    m0 = mcnt1;
    press(1);
    check("m1_step3", 32'(step1), 32'd3);
    check("m1_match_pulse_cycles", 32'(mcnt1 - m0), 32'd1);
    check("m1_mask", 32'(mask1), 32'h9);
    check("m1_score", 32'(score1), 32'd1);
    press(1); check("m1_step4", 32'(step1), 32'd4);
    press(1); check("m1_step5", 32'(step1), 32'd5);
    press(1); check("m1_step0", 32'(step1), 32'd0);
    check("m1_done", 32'(done1), 32'd0);

    // Re-select an already-matched pair, same square twice, out of range.
    sa1 = 3'd0; sb1 = 3'd3;
    press(1); press(1); press(1);
    check("rs_step", 32'(step1), 32'd0);
    check("rs_misses", 32'(miss1), 32'd2);
    check("rs_score", 32'(score1), 32'd1);
    sa1 = 3'd2; sb1 = 3'd2;
    press(1); press(1); press(1);
    check("same_misses", 32'(miss1), 32'd3);
    sa1 = 3'd4; sb1 = 3'd7;
    press(1); press(1); press(1);
    check("oor_misses", 32'(miss1), 32'd4);
    check("oor_mask", 32'(mask1), 32'h9);

    // Completion with 1/2.
    sa1 = 3'd1; sb1 = 3'd2;
    press(1); press(1);
    m0 = mcnt1;
    press(1);
    check("c_step3", 32'(step1), 32'd3);
    check("c_match_pulse_cycles", 32'(mcnt1 - m0), 32'd1);
    check("c_score", 32'(score1), 32'd2);
    check("c_mask", 32'(mask1), 32'hf);
    press(1); check("c_step4", 32'(step1), 32'd4);
    press(1); check("c_step5", 32'(step1), 32'd5);
    check("c_not_done_yet", 32'(done1), 32'd0);
    press(1); check("c_step6", 32'(step1), 32'd6);
    check("c_done", 32'(done1), 32'd1);
    for (int i = 0; i < 5; i++) press(1);
    check("c_hold_step", 32'(step1), 32'd6);
    check("c_hold_score", 32'(score1), 32'd2);
    check("c_hold_misses", 32'(miss1), 32'd4);
    check("c_hold_done", 32'(done1), 32'd1);

    // Button held across reset release: no advance.
    @(negedge clk); rst = 1'b1; btn1 = 1'b1;
    @(negedge clk);
    check_zero1("rstbtn");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstbtn_held_step", 32'(step1), 32'd0);
    btn1 = 1'b0;
    repeat (3) @(negedge clk);

    // Held 50 cycles: one advance, two edges after first sampled-high edge.
    btn1 = 1'b1;
    @(negedge clk); check("hold_edge_k", 32'(step1), 32'd0);
    @(negedge clk); check("hold_edge_k1", 32'(step1), 32'd0);
    @(negedge clk); check("hold_edge_k2", 32'(step1), 32'd1);
    repeat (47) @(negedge clk);
    btn1 = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_single_advance", 32'(step1), 32'd1);

    // Reach step 4 and pulse reset between clock edges.
    sa1 = 3'd3; sb1 = 3'd0;
    press(1); press(1); press(1);
    check("ar_step4", 32'(step1), 32'd4);
    check("ar_score", 32'(score1), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero1("async_rst");
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Adjacent rule, 8 squares.
    sa2 = 3'd4; sb2 = 3'd5;
    press(2); press(2);
    m0 = mcnt2;
    press(2);
    check("adj_step3", 32'(step2), 32'd3);
    check("adj_mask", 32'(mask2), 32'h30);
    check("adj_score", 32'(score2), 32'd1);
    check("adj_match_pulse_cycles", 32'(mcnt2 - m0), 32'd1);
    press(2); press(2); press(2);
    check("adj_back_idle", 32'(step2), 32'd0);
    check("adj_done", 32'(done2), 32'd0);
    sa2 = 3'd3; sb2 = 3'd4;
    x0 = xcnt2;
    press(2); press(2); press(2);
    check("adj_miss_step", 32'(step2), 32'd0);
    check("adj_misses", 32'(miss2), 32'd1);
    for (int i = 0; i < 253; i++) begin
      press(2); press(2); press(2);
    end
    check("sat_254", 32'(miss2), 32'd254);
    for (int i = 0; i < 46; i++) begin
      press(2); press(2); press(2);
    end
    check("sat_255", 32'(miss2), 32'd255);
    check("sat_pulse_cycles", 32'(xcnt2 - x0), 32'd300);
    check("sat_mask", 32'(mask2), 32'h30);
    check("sat_score", 32'(score2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_step_ctrl.md
Name: game_step_ctrl

Overview:
Parametrised step sequencer for the colour-matching game. It runs in the system clock domain and synchronises and edge-detects the raw player button internally. For each attempt it steps through select-first, select-second, evaluate and reveal phases, checking the two selected square indices against a configurable pairing rule. It tracks which squares are already matched, keeps score and miss counters, and reports game completion to the display/VGA logic.

Parameters:
NUM_SQ, 4, number of squares; must be even and >= 2
IDX_W, 3, width of square-index inputs; 2^IDX_W >= NUM_SQ
PAIR_MODE, 0, pairing rule: 0 = mirror (a+b == NUM_SQ-1), 1 = adjacent (a == b^1)
REVEAL_STEPS, 3, button presses spent in reveal after a match; >= 1
MISS_W, 8, width of the saturating miss counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn  in  1  raw player button level, asynchronous to clk
sel_a  in  IDX_W  first selected square index ("variety")
sel_b  in  IDX_W  second selected square index ("match")
step  out  STEP_W  current phase, STEP_W = clog2(REVEAL_STEPS+4)
matched_mask  out  NUM_SQ  bit i set = square i permanently matched
score  out  clog2(NUM_SQ/2+1)  pairs matched so far
misses  out  MISS_W  failed evaluations, saturating
match_pulse  out  1  one-cycle strobe on successful evaluation
miss_pulse  out  1  one-cycle strobe on failed evaluation
done  out  1  all NUM_SQ/2 pairs matched; sticky

Behaviour:
- Reset (async, rst=1): step=0, matched_mask=0, score=0, misses=0, pulses=0, done=0. Synchroniser flops and the previous-level flop reset to 1, so a button held through reset release produces no press.
- Press detection: 2-flop synchroniser on btn, then press = sync2 & ~prev. State advances on the clk edge where press=1. A btn rise sampled at edge k updates step at edge k+2.
- One press advances at most one phase. A continuously held btn is one press.
- Step encoding: 0 IDLE, 1 FIRST, 2 SECOND, 3..2+REVEAL_STEPS REVEAL, DONE = 3+REVEAL_STEPS.
- Transitions on press:
  - 0 -> 1; 1 -> 2.
  - 2 -> evaluate sel_a/sel_b, sampled on this same edge. sel_a/sel_b must be stable for 2 cycles before the press.
  - Valid pair requires all of: sel_a != sel_b; both < NUM_SQ; pairing rule holds (either order); neither bit set in matched_mask.
    - Valid: set both mask bits, score+1, match_pulse=1 for one cycle, step -> 3.
    - Invalid: misses+1 (holds at all-ones), miss_pulse=1 for one cycle, step -> 0, mask unchanged.
  - REVEAL r (r < 2+REVEAL_STEPS) -> r+1.
  - Last REVEAL -> DONE if score == NUM_SQ/2, else -> 0.
  - DONE: ignores presses; held until rst.
- done = (step == DONE), registered with step.
- No press: all state holds. Pulses are 0 except in the cycle immediately after an evaluating edge.
- Reset asserted mid-operation (any step): immediate async clear of everything. No partial score is retained.
- Out-of-range indices (>= NUM_SQ) are always a miss and never index matched_mask.

Test Plan:
1. Defaults. Reset, then press 3x with sel_a=3, sel_b=0 -> step 1,2,3; match_pulse for exactly 1 cycle; matched_mask=4'b1001; score=1. Press 3x more -> step 4,5,0.
2. Mismatch. From step 2 with sel_a=0, sel_b=1 -> step=0, misses=1, miss_pulse 1 cycle, mask unchanged, score unchanged.
3. Re-select. After scenario 1, attempt sel_a=0, sel_b=3 -> miss; misses increments; score stays 1. Also sel_a=sel_b=2 -> miss.
4. Completion. After scenario 1, match sel_a=1, sel_b=2 -> score=2, mask=4'b1111. Presses take step 3,4,5,6; done=1. Five further presses leave step=6 and all counters unchanged.
5. Button/reset timing:
   - btn held high 50 cycles -> exactly one step advance, visible 2 edges after first sampled-high edge.
   - btn held high across rst deassert -> no advance.
   - rst pulsed while step=4 -> all outputs 0 without a clock edge.
6. PAIR_MODE=1, NUM_SQ=8, IDX_W=3: pair 4/5 -> match; pair 3/4 -> miss. 300 forced misses -> misses saturates at 255.
